// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and execute-side handshake bundle for decode_stage
// master drives instructions and out_ready, slave is the decode stage itself.
interface decode_stage_if #(
  parameter int INSTRUCTION_SIZE = 20,
  parameter int OP_SIZE          = 6,
  parameter int REG_ADDRESS_SIZE = 2,
  parameter int DATA_WIDTH       = 16,
  parameter int PC_WIDTH         = 12
);
  logic                        in_valid;
  logic                        in_ready;
  logic [INSTRUCTION_SIZE-1:0] in_instruction;
  logic [PC_WIDTH-1:0]         in_pc;

  logic                        out_valid;
  logic                        out_ready;
  logic [OP_SIZE-1:0]          out_opcode;
  logic [1:0]                  out_format;
  logic [REG_ADDRESS_SIZE-1:0] out_rAlpha;
  logic [REG_ADDRESS_SIZE-1:0] out_rBeta;
  logic [REG_ADDRESS_SIZE-1:0] out_rGamma;
  logic [DATA_WIDTH-1:0]       out_imm;
  logic [PC_WIDTH-1:0]         out_jump_target;
  logic [PC_WIDTH-1:0]         out_pc;

  modport master (
    output in_valid, in_instruction, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_format, out_rAlpha, out_rBeta,
           out_rGamma, out_imm, out_jump_target, out_pc
  );

  modport slave (
    input  in_valid, in_instruction, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_format, out_rAlpha, out_rBeta,
           out_rGamma, out_imm, out_jump_target, out_pc
  );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered instruction decode stage with backpressure and flush
// Define DECODE_HAZARD_EN to add the load-use interlock and the hazard_stalls counter.
module decode_stage #(
  parameter int                  INSTRUCTION_SIZE     = 20,
  parameter int                  OP_SIZE              = 6,
  parameter int                  REG_ADDRESS_SIZE     = 2,
  parameter int                  SMALL_IMMEDIATE_SIZE = 10,
  parameter int                  BIG_IMMEDIATE_SIZE   = 12,
  parameter int                  JUMP_ADDRESS_SIZE    = 9,
  parameter int                  DATA_WIDTH           = 16,
  parameter int                  PC_WIDTH             = 12,
  parameter logic [OP_SIZE-1:0]  LOAD_OPCODE          = 6'h14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  decode_stage_if.slave        bus,
  output logic [15:0]          hazard_stalls_o
);

  localparam int OP_LSB = INSTRUCTION_SIZE - OP_SIZE;
  localparam int RA_LSB = OP_LSB - REG_ADDRESS_SIZE;
  localparam int RB_LSB = RA_LSB - REG_ADDRESS_SIZE;
  localparam int RG_LSB = RB_LSB - REG_ADDRESS_SIZE;
  localparam int JT_W   = JUMP_ADDRESS_SIZE + 2;

  localparam logic [1:0] FMT_R  = 2'b00;
  localparam logic [1:0] FMT_RI = 2'b01;
  localparam logic [1:0] FMT_LI = 2'b10;

  logic [OP_SIZE-1:0]              dec_opcode;
  logic [1:0]                      dec_format;
  logic [REG_ADDRESS_SIZE-1:0]     dec_ra;
  logic [REG_ADDRESS_SIZE-1:0]     dec_rb;
  logic [REG_ADDRESS_SIZE-1:0]     dec_rg;
  logic [SMALL_IMMEDIATE_SIZE-1:0] dec_small;
  logic [BIG_IMMEDIATE_SIZE-1:0]   dec_big;
  logic [DATA_WIDTH-1:0]           dec_imm;
  logic [JT_W-1:0]                 jt_raw;
  logic [PC_WIDTH-1:0]             dec_jt;

  logic                            valid_q, valid_d;
  logic [OP_SIZE-1:0]              opcode_q, opcode_d;
  logic [1:0]                      format_q, format_d;
  logic [REG_ADDRESS_SIZE-1:0]     ra_q, ra_d;
  logic [REG_ADDRESS_SIZE-1:0]     rb_q, rb_d;
  logic [REG_ADDRESS_SIZE-1:0]     rg_q, rg_d;
  logic [DATA_WIDTH-1:0]           imm_q, imm_d;
  logic [PC_WIDTH-1:0]             jt_q, jt_d;
  logic [PC_WIDTH-1:0]             pc_q, pc_d;

  logic                            interlock;
  logic                            accept;

  assign dec_opcode = bus.in_instruction[INSTRUCTION_SIZE-1:OP_LSB];
  assign dec_format = dec_opcode[OP_SIZE-1:OP_SIZE-2];
  assign dec_ra     = bus.in_instruction[RA_LSB +: REG_ADDRESS_SIZE];
  assign dec_rb     = bus.in_instruction[RB_LSB +: REG_ADDRESS_SIZE];
  assign dec_rg     = bus.in_instruction[RG_LSB +: REG_ADDRESS_SIZE];
  assign dec_small  = bus.in_instruction[SMALL_IMMEDIATE_SIZE-1:0];
  assign dec_big    = bus.in_instruction[BIG_IMMEDIATE_SIZE-1:0];
  assign jt_raw     = {bus.in_instruction[OP_LSB-1:OP_LSB-JUMP_ADDRESS_SIZE], 2'b00};

  // Word-aligned jump field is fitted to PC_WIDTH by zero-extension or truncation.
  if (JT_W >= PC_WIDTH) begin : g_jt_trunc
    assign dec_jt = jt_raw[PC_WIDTH-1:0];
  end else begin : g_jt_ext
    assign dec_jt = {{(PC_WIDTH-JT_W){1'b0}}, jt_raw};
  end

  always_comb begin
    dec_imm = '0;
    case (dec_format)
      FMT_RI:  dec_imm = {{(DATA_WIDTH-SMALL_IMMEDIATE_SIZE){dec_small[SMALL_IMMEDIATE_SIZE-1]}},
                          dec_small};
      FMT_LI:  dec_imm = {{(DATA_WIDTH-BIG_IMMEDIATE_SIZE){dec_big[BIG_IMMEDIATE_SIZE-1]}},
                          dec_big};
      default: dec_imm = '0;
    endcase
  end

`ifdef DECODE_HAZARD_EN
  logic        src_hit;
  logic [15:0] stalls_q, stalls_d;

  always_comb begin
    src_hit = 1'b0;
    case (dec_format)
      FMT_R:   src_hit = (dec_rb == ra_q) || (dec_rg == ra_q);
      FMT_RI:  src_hit = (dec_ra == ra_q) || (dec_rb == ra_q);
      default: src_hit = 1'b0;
    endcase
  end

  assign interlock = valid_q && bus.out_ready && (opcode_q == LOAD_OPCODE) &&
                     bus.in_valid && src_hit;

  always_comb begin
    stalls_d = stalls_q;
    if (interlock && !flush_i && (stalls_q != 16'hFFFF)) begin
      stalls_d = stalls_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stalls_q <= '0;
    end else begin
      stalls_q <= stalls_d;
    end
  end

  assign hazard_stalls_o = stalls_q;
`else
  assign interlock       = 1'b0;
  assign hazard_stalls_o = '0;
`endif

  assign bus.in_ready = !flush_i && !interlock && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // accept already excludes flush, so flush only needs to drop the held word.
  always_comb begin
    valid_d  = valid_q;
    opcode_d = opcode_q;
    format_d = format_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rg_d     = rg_q;
    imm_d    = imm_q;
    jt_d     = jt_q;
    pc_d     = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      opcode_d = dec_opcode;
      format_d = dec_format;
      ra_d     = dec_ra;
      rb_d     = dec_rb;
      rg_d     = dec_rg;
      imm_d    = dec_imm;
      jt_d     = dec_jt;
      pc_d     = bus.in_pc;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      opcode_q <= '0;
      format_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rg_q     <= '0;
      imm_q    <= '0;
      jt_q     <= '0;
      pc_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      format_q <= format_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rg_q     <= rg_d;
      imm_q    <= imm_d;
      jt_q     <= jt_d;
      pc_q     <= pc_d;
    end
  end

  assign bus.out_valid       = valid_q;
  assign bus.out_opcode      = opcode_q;
  assign bus.out_format      = format_q;
  assign bus.out_rAlpha      = ra_q;
  assign bus.out_rBeta       = rb_q;
  assign bus.out_rGamma      = rg_q;
  assign bus.out_imm         = imm_q;
  assign bus.out_jump_target = jt_q;
  assign bus.out_pc          = pc_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage
// Hazard expectations follow DECODE_HAZARD_EN.
module tb_decode_stage;

  typedef struct packed {
    logic [5:0]  op;
    logic [1:0]  fmt;
    logic [1:0]  ra;
    logic [1:0]  rb;
    logic [1:0]  rg;
    logic [15:0] imm;
    logic [11:0] jt;
    logic [11:0] pc;
  } exp_t;

`ifdef DECODE_HAZARD_EN
  localparam int          EXP_GAP    = 2;
  localparam logic [15:0] EXP_STALLS = 16'd1;
`else
  localparam int          EXP_GAP    = 1;
  localparam logic [15:0] EXP_STALLS = 16'd0;
`endif

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [15:0] hazard_stalls;

  int   checks;
  int   errors;
  int   cyc;
  exp_t sb[$];
  int   fire_cyc[$];

  decode_stage_if #(
    .INSTRUCTION_SIZE(20), .OP_SIZE(6), .REG_ADDRESS_SIZE(2), .DATA_WIDTH(16), .PC_WIDTH(12)
  ) bus ();

  decode_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_i         (flush),
    .bus             (bus.slave),
    .hazard_stalls_o (hazard_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [5:0] op, input logic [1:0] fmt, input logic [1:0] ra,
                              input logic [1:0] rb, input logic [1:0] rg, input logic [15:0] imm,
                              input logic [11:0] jt, input logic [11:0] pc);
    exp_t e;
    e.op = op; e.fmt = fmt; e.ra = ra; e.rb = rb; e.rg = rg; e.imm = imm; e.jt = jt; e.pc = pc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, req);
    end
  endtask

  // Holds the word until the DUT takes it; the expectation is queued at the accepting edge.
  task automatic send(input logic [19:0] w, input logic [11:0] pc, input exp_t e);
    int n;
    n = 0;
    bus.in_valid       = 1'b1;
    bus.in_instruction = w;
    bus.in_pc          = pc;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout word %h got in_ready=0 expected 1", w);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      fire_cyc.push_back(cyc);
      a = {bus.out_opcode, bus.out_format, bus.out_rAlpha, bus.out_rBeta, bus.out_rGamma,
           bus.out_imm, bus.out_jump_target, bus.out_pc};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got %h expected none", a);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL decoded_word got %h expected %h", a, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instruction = '0;
    bus.in_pc = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_fields", 64'({bus.out_opcode, bus.out_imm, bus.out_jump_target, bus.out_pc}), 64'd0);
    chk("reset_stalls", 64'(hazard_stalls), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back decode of each format, including boundary immediates.
    bus.out_ready = 1'b1;
    fire_cyc.delete();
    send(20'h41BFF, 12'h100, mk(6'h10, 2'b01, 2'd1, 2'd2, 2'd3, 16'hFFFF, 12'h37C, 12'h100));
    send(20'h837FF, 12'h104, mk(6'h20, 2'b10, 2'd3, 2'd1, 2'd3, 16'h07FF, 12'h6FC, 12'h104));
    send(20'hC3560, 12'h010, mk(6'h30, 2'b11, 2'd3, 2'd1, 2'd1, 16'h0000, 12'h6AC, 12'h010));
    send(20'h00FFF, 12'h108, mk(6'h00, 2'b00, 2'd0, 2'd3, 2'd3, 16'h0000, 12'h1FC, 12'h108));
    send(20'h401FF, 12'h10C, mk(6'h10, 2'b01, 2'd0, 2'd0, 2'd1, 16'h01FF, 12'h03C, 12'h10C));
    repeat (3) @(posedge clk);
    chk("throughput_span", 64'(fire_cyc[$] - fire_cyc[0]), 64'd4);
    #1;

    // Backpressure: out_ready low for three cycles after the first word lands.
    fork
      begin
        send(20'h41BFF, 12'h200, mk(6'h10, 2'b01, 2'd1, 2'd2, 2'd3, 16'hFFFF, 12'h37C, 12'h200));
        send(20'h837FF, 12'h204, mk(6'h20, 2'b10, 2'd3, 2'd1, 2'd3, 16'h07FF, 12'h6FC, 12'h204));
        send(20'hC3560, 12'h208, mk(6'h30, 2'b11, 2'd3, 2'd1, 2'd1, 16'h0000, 12'h6AC, 12'h208));
      end
      begin
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
          chk("stall_hold_pc", 64'({bus.out_valid, bus.out_pc}), 64'h1200);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Flush with a held word and a new word both pending.
    bus.out_ready = 1'b0;
    send(20'h837FF, 12'h300, mk(6'h20, 2'b10, 2'd3, 2'd1, 2'd3, 16'h07FF, 12'h6FC, 12'h300));
    bus.in_valid = 1'b1;
    bus.in_instruction = 20'h41BFF;
    bus.in_pc = 12'h304;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    chk("flush_pre_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    void'(sb.pop_back());
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset while a word is held.
    bus.out_ready = 1'b0;
    send(20'hC3560, 12'h400, mk(6'h30, 2'b11, 2'd3, 2'd1, 2'd1, 16'h0000, 12'h6AC, 12'h400));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(bus.out_valid), 64'd0);
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // Load followed by an instruction with no source registers: never stalls.
    fire_cyc.delete();
    send(20'h51000, 12'h500, mk(6'h14, 2'b01, 2'd1, 2'd0, 2'd0, 16'h0000, 12'h200, 12'h500));
    send(20'h837FF, 12'h504, mk(6'h20, 2'b10, 2'd3, 2'd1, 2'd3, 16'h07FF, 12'h6FC, 12'h504));
    repeat (4) @(posedge clk);
    chk("no_hazard_gap", 64'(fire_cyc[$] - fire_cyc[$-1]), 64'd1);
    chk("no_hazard_stalls", 64'(hazard_stalls), 64'd0);
    #1;

    // Load-use: R-format consumer reads the load's rAlpha through rBeta.
    fire_cyc.delete();
    send(20'h51000, 12'h600, mk(6'h14, 2'b01, 2'd1, 2'd0, 2'd0, 16'h0000, 12'h200, 12'h600));
    send(20'h00700, 12'h604, mk(6'h00, 2'b00, 2'd0, 2'd1, 2'd3, 16'h0000, 12'h0E0, 12'h604));
    repeat (4) @(posedge clk);
    chk("hazard_gap", 64'(fire_cyc[$] - fire_cyc[$-1]), 64'(EXP_GAP));
    chk("hazard_stalls", 64'(hazard_stalls), 64'(EXP_STALLS));

    @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered instruction-decode pipeline stage between fetch and execute. It accepts one raw instruction word plus its PC per valid/ready handshake. It classifies the instruction format from the opcode, extracts the register fields, sign-extends the immediate to the datapath width and forms the jump target. Results are presented one cycle later with backpressure, flush, and an optional load-use interlock.

## Interface
- INSTRUCTION_SIZE, 20, instruction word width
- OP_SIZE, 6, opcode width (instruction MSBs)
- REG_ADDRESS_SIZE, 2, register-select width
- SMALL_IMMEDIATE_SIZE, 10, RI-format immediate width (instruction LSBs)
- BIG_IMMEDIATE_SIZE, 12, LI-format immediate width (instruction LSBs)
- JUMP_ADDRESS_SIZE, 9, jump field width, directly below opcode
- DATA_WIDTH, 16, sign-extended immediate width
- PC_WIDTH, 12, PC / jump target width
- LOAD_OPCODE, 6'h14, opcode of the load instruction
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage accepts this cycle
- in_instruction  in  INSTRUCTION_SIZE  raw word
- in_pc  in  PC_WIDTH  PC of word
- flush  in  1  synchronous kill of held and incoming instruction
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  downstream accepts
- out_opcode  out  OP_SIZE  opcode
- out_format  out  2  00 R, 01 RI, 10 LI, 11 J
- out_rAlpha / out_rBeta / out_rGamma  out  REG_ADDRESS_SIZE  each  register fields
- out_imm  out  DATA_WIDTH  sign-extended immediate
- out_jump_target  out  PC_WIDTH  {jump field, 2'b00}, zero-extended or truncated to PC_WIDTH
- out_pc  out  PC_WIDTH  registered in_pc
- hazard_stalls  out  16  saturating interlock-bubble count (0 when macro absent)

## Operation
- Field layout, OP_LSB = INSTRUCTION_SIZE-OP_SIZE:
  - opcode = [INSTRUCTION_SIZE-1:OP_LSB].
  - rAlpha, rBeta, rGamma occupy consecutive REG_ADDRESS_SIZE fields immediately below the opcode.
  - Small immediate = [SMALL_IMMEDIATE_SIZE-1:0]; big immediate = [BIG_IMMEDIATE_SIZE-1:0].
  - Jump field = [OP_LSB-1:OP_LSB-JUMP_ADDRESS_SIZE].
- out_format = opcode[OP_SIZE-1:OP_SIZE-2].
- out_imm by format:
  - R: 0.
  - RI: sign-extended small immediate.
  - LI: sign-extended big immediate.
  - J: 0.
- Register fields are always extracted raw, regardless of format.
- Source registers per format:
  - R: rBeta, rGamma.
  - RI: rAlpha, rBeta.
  - LI, J: none.
- Output register loads on accept (in_valid && in_ready).
- in_ready = !flush && !interlock && (!out_valid || out_ready).
- On out_ready && out_valid with no accept, out_valid clears next cycle.
- Simultaneous fire and accept: the new instruction replaces the old one, with no gap.
- flush: out_valid = 0 next cycle; the incoming word is not accepted; flush has priority over all events.
- Reset mid-operation: out_valid drops asynchronously and the held instruction is lost.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 per cycle while out_ready is high.
- Reset values: all outputs 0; in_ready reflects 0 state (1 unless flush asserted).
- in_ready depends combinationally on out_ready and flush.
- Outputs are stable while out_valid && !out_ready.
- Interlock (macro only): asserted when all of the following hold:
  - out_valid && out_ready;
  - out_opcode == LOAD_OPCODE;
  - in_valid, and the incoming instruction's source register equals out_rAlpha.
- Interlock effect:
  - in_ready = 0 for that cycle, and the load drains.
  - out_valid = 0 next cycle (one bubble); the consumer is accepted the cycle after.
  - hazard_stalls increments per bubble and saturates at 16'hFFFF.

## Configuration
- DECODE_HAZARD_EN defined: load-use interlock and hazard_stalls counter are present.
- Undefined: interlock is tied 0, hazard_stalls is tied 0, and no hazard logic is synthesised.

## Test plan
- RI decode: 20'h41BFF, out_ready=1.
  - Next cycle: out_format=01, rAlpha=1, rBeta=2, out_imm=16'hFFFF.
- LI decode: 20'h837FF.
  - out_format=10, rAlpha=3, out_imm=16'h07FF.
- Jump decode: 20'hC3560, in_pc=12'h010.
  - out_format=11, out_jump_target=12'h6AC, out_imm=0, out_pc=12'h010.
- Backpressure: three back-to-back words, with out_ready low for cycles 2–4.
  - in_ready is low, outputs hold the first word, and no word is lost or duplicated.
  - Order is preserved.
- Flush: assert flush while out_valid=1 and in_valid=1.
  - out_valid=0 next cycle and the incoming word is dropped.
- Hazard (DECODE_HAZARD_EN): load 20'h51000 (rAlpha=1), followed by 20'h00700 (R, rBeta=1).
  - Exactly one bubble; hazard_stalls=1.
  - Without the macro: no bubble, hazard_stalls=0.
